// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for an 8:1 W-bit select datapath with a registered, valid/ready output.
// Optional grant abandonment on downstream stall: define MUXARB_TIMEOUT_EN.
module mux_rr_arbiter #(
    parameter int W       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [7:0]     REQ,
    input  logic [8*W-1:0] DIN,
    input  logic           RDY,
    output logic           VLD,
    output logic [7:0]     GNT,
    output logic [2:0]     SEL,
    output logic [W-1:0]   O
`ifdef MUXARB_TIMEOUT_EN
    ,
    output logic           TOUT
`endif
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("mux_rr_arbiter: TIMEOUT must be in 2..255");
    end

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state;
    logic [2:0] ptr;
    logic       any_req;
    logic [2:0] win;
    logic [2:0] idx;
    logic       release_grant;
    logic       timeout_hit;

`ifdef MUXARB_TIMEOUT_EN
    logic [7:0] stall_cnt;
    assign timeout_hit = (state == BUSY) && !RDY && (stall_cnt == 8'(TIMEOUT - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Search REQ starting at ptr; the 3-bit sum wraps modulo 8 on its own.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        idx     = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            idx = ptr + 3'(k);
            if (!any_req && REQ[idx]) begin
                any_req = 1'b1;
                win     = idx;
            end
        end
    end

    // Idle, handshake and abandonment all re-arbitrate identically.
    assign release_grant = (state == IDLE) || RDY || timeout_hit;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            VLD   <= 1'b0;
            GNT   <= '0;
            SEL   <= '0;
            O     <= '0;
            ptr   <= '0;
`ifdef MUXARB_TIMEOUT_EN
            stall_cnt <= '0;
            TOUT      <= 1'b0;
`endif
        end else begin
`ifdef MUXARB_TIMEOUT_EN
            TOUT <= timeout_hit;
`endif
            if (release_grant) begin
                if (any_req) begin
                    state <= BUSY;
                    VLD   <= 1'b1;
                    GNT   <= 8'b1 << win;
                    SEL   <= win;
                    O     <= DIN[win*W +: W];
                    ptr   <= win + 3'd1;
`ifdef MUXARB_TIMEOUT_EN
                    stall_cnt <= '0;
`endif
                end else begin
                    state <= IDLE;
                    VLD   <= 1'b0;
                    GNT   <= '0;
                end
            end
`ifdef MUXARB_TIMEOUT_EN
            else begin
                stall_cnt <= stall_cnt + 8'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural round-robin model.
module tb_mux_rr_arbiter;

    localparam int W  = 4;
    localparam int TO = 4;
`ifdef MUXARB_TIMEOUT_EN
    localparam int STALLS = 2;
`else
    localparam int STALLS = 5;
`endif

    logic           CLK = 1'b0;
    logic           RST;
    logic [7:0]     REQ;
    logic [8*W-1:0] DIN;
    logic           RDY;
    logic           VLD;
    logic [7:0]     GNT;
    logic [2:0]     SEL;
    logic [W-1:0]   O;
`ifdef MUXARB_TIMEOUT_EN
    logic           TOUT;
`endif

    mux_rr_arbiter #(.W(W), .TIMEOUT(TO)) dut (
        .CLK (CLK),
        .RST (RST),
        .REQ (REQ),
        .DIN (DIN),
        .RDY (RDY),
        .VLD (VLD),
        .GNT (GNT),
        .SEL (SEL),
        .O   (O)
`ifdef MUXARB_TIMEOUT_EN
        ,
        .TOUT(TOUT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: who holds the grant, its captured word, the search start and grant age.
    bit           m_busy;
    int           m_sel;
    int           m_ptr;
    int           m_age;
    logic [W-1:0] m_o;
    bit           m_tout;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++)
            if (r[(p + k) % 8]) return (p + k) % 8;
        return -1;
    endfunction

    task automatic model_edge();
        bit rel;
        int w;
        if (RST) begin
            m_busy = 0; m_sel = 0; m_ptr = 0; m_age = 0; m_o = '0; m_tout = 0;
        end else begin
            m_tout = 0;
            rel = !m_busy || RDY;
`ifdef MUXARB_TIMEOUT_EN
            if (m_busy && !RDY && m_age + 1 == TO) begin
                rel = 1;
                m_tout = 1;
            end
`endif
            if (rel) begin
                w = pick(REQ, m_ptr);
                if (w >= 0) begin
                    m_busy = 1;
                    m_sel  = w;
                    m_o    = DIN[w*W +: W];
                    m_ptr  = (w + 1) % 8;
                    m_age  = 0;
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic compare_all();
        check("vld", 32'(VLD), 32'(m_busy));
        check("gnt", 32'(GNT), m_busy ? (32'd1 << m_sel) : 32'd0);
        check("sel", 32'(SEL), 32'(m_sel));
        check("o",   32'(O),   32'(m_o));
`ifdef MUXARB_TIMEOUT_EN
        check("tout", 32'(TOUT), 32'(m_tout));
`endif
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        REQ = '0;
        RDY = 1'b1;
        step();
        RST = 1'b0;
    endtask

    initial begin
        // Reset with everyone requesting
        RST = 1'b1; REQ = 8'hFF; RDY = 1'b1; DIN = 32'($urandom);
        step();
        check("rst_gnt", 32'(GNT), 32'h0);
        step();
        check("rst_o", 32'(O), 32'h0);
        RST = 1'b0;
        step();
        check("first_gnt", 32'(GNT), 32'h01);

        // Single requester, then drop at acknowledge
        do_reset();
        REQ = 8'h04; DIN = '0; DIN[2*W +: W] = 4'hA; RDY = 1'b1;
        step();
        check("single_gnt", 32'(GNT), 32'h04);
        check("single_sel", 32'(SEL), 32'd2);
        check("single_o",   32'(O),   32'hA);
        REQ = 8'h00;
        step();
        check("single_drop", 32'(VLD), 32'd0);

        // Full rotation
        do_reset();
        REQ = 8'hFF; RDY = 1'b1;
        for (int i = 0; i < 8; i++) DIN[i*W +: W] = W'(i + 1);
        for (int k = 0; k < 9; k++) begin
            step();
            check("rot_sel", 32'(SEL), 32'(k % 8));
            check("rot_o",   32'(O),   32'(k % 8 + 1));
        end

        // Backpressure on requester 3
        do_reset();
        REQ = 8'h08; RDY = 1'b1; DIN = 32'($urandom);
        step();
        RDY = 1'b0;
        for (int k = 0; k < STALLS; k++) begin
            REQ = 8'($urandom); DIN = 32'($urandom);
            step();
            check("bp_gnt", 32'(GNT), 32'h08);
            check("bp_sel", 32'(SEL), 32'd3);
        end
        RDY = 1'b1; REQ = 8'h25;
        step();
        check("bp_next", 32'(SEL), 32'd5);

        // Wrap-around from 6
        do_reset();
        REQ = 8'h40; RDY = 1'b1;
        step();
        REQ = 8'h41;
        step();
        check("wrap_0", 32'(SEL), 32'd0);
        step();
        check("wrap_6", 32'(SEL), 32'd6);

`ifdef MUXARB_TIMEOUT_EN
        // Grant abandoned after TO stalled cycles
        do_reset();
        REQ = 8'h02; RDY = 1'b0;
        step();
        REQ = 8'h22;
        for (int k = 0; k < TO - 1; k++) begin
            step();
            check("to_hold", 32'(GNT), 32'h02);
        end
        step();
        check("to_gnt",  32'(GNT),  32'h20);
        check("to_sel",  32'(SEL),  32'd5);
        check("to_tout", 32'(TOUT), 32'd1);
        step();
        check("to_pulse", 32'(TOUT), 32'd0);
`endif

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            RST = ($urandom % 250) == 0;
            REQ = ($urandom % 8 == 0) ? 8'h00 : 8'($urandom & $urandom);
            RDY = ($urandom % 4) != 0;
            DIN = 32'($urandom);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

- Round-robin arbiter and sequencer for the 8:1 W-bit select datapath.
- Takes eight requesters, each with a request line and a W-bit data slice. Grants one requester at a time and drives the 3-bit select.
- Presents the selected data on a registered output with a valid/ready handshake toward the downstream consumer.
- Sits between the requester bank and the shared output channel; replaces a free-running or testbench-driven select.

## Interface
Parameters:
- W, 4 — data width per requester and of O.
- TIMEOUT, 15 — stall cycles before a grant is abandoned. Used only with MUXARB_TIMEOUT_EN; legal range 2..255.

Ports:
- CLK  input  1  — single clock; all state updates on the rising edge.
- RST  input  1  — synchronous, active-high reset.
- REQ  input  8  — REQ[i]=1: requester i has data pending.
- DIN  input  8*W  — packed data; slice i is DIN[i*W +: W].
- RDY  input  1  — downstream accepts O when VLD=1.
- VLD  output  1  — O holds a granted word.
- GNT  output  8  — one-hot grant, all zero when idle; GNT[i]&RDY is requester i's acknowledge.
- SEL  output  3  — binary index of the current/last grant; drives the mux select.
- O  output  W  — latched data of the granted requester.
- TOUT  output  1  — one-cycle pulse when a grant is abandoned. Present only with MUXARB_TIMEOUT_EN.

## Operation
- Reset: VLD=0, GNT=8'h00, SEL=3'b000, O=0, TOUT=0, priority pointer PTR=0, stall counter=0.
- There are two states:
  - IDLE (VLD=0).
  - BUSY (VLD=1).
- Arbitration searches REQ at indices PTR, PTR+1, …, PTR+7 (mod 8). The first set bit wins.
  - On a win at index i, the block loads GNT=1<<i, SEL=i, O=DIN slice i (captured at the grant edge), and sets VLD=1.
  - PTR is loaded with i+1 mod 8 (7 wraps to 0).
- IDLE: if any REQ bit is set, arbitrate and go to BUSY; otherwise stay in IDLE.
- BUSY with RDY=0: GNT, SEL and O are frozen regardless of REQ or DIN changes.
- BUSY with RDY=1 (handshake):
  - If any REQ bit is set, re-arbitrate in the same edge and stay in BUSY (back-to-back, no bubble).
  - Otherwise go to IDLE with VLD=0 and GNT=0.
  - SEL keeps its last value while idle.
- The granted requester is lowest priority at the next arbitration. If it keeps REQ high and is the only requester, it is regranted.
- Requesters change DIN only after acknowledge. DIN changes while granted are ignored, because O is already latched.

## Timing
- Latency: REQ sampled at edge k in IDLE gives VLD, GNT, SEL and O valid after edge k (1 cycle).
- Handshake completes at an edge where VLD=1 and RDY=1. The next word, if any, is valid after that same edge, giving a throughput of 1 word per cycle.
- Simultaneous REQ bits: resolved purely by PTR order. No starvation: each requester waits at most 7 grants.
- RST=1 overrides everything at the edge. An outstanding grant is dropped with no acknowledge and all outputs return to reset values.
- With REQ=0 and RDY=1 in BUSY, VLD falls after the handshake edge.

## Configuration
- MUXARB_TIMEOUT_EN defined:
  - The stall counter increments every BUSY cycle with RDY=0 and clears on every new grant.
  - At the edge where the counter equals TIMEOUT-1 and RDY=0, the grant is abandoned: VLD has been high for TIMEOUT cycles.
  - The block then arbitrates exactly as on a handshake; no acknowledge is issued.
  - TOUT=1 for the following cycle.
  - PTR is already past the abandoned requester, so it is not regranted ahead of others.
- MUXARB_TIMEOUT_EN undefined:
  - No counter and no TOUT port.
  - A grant holds indefinitely until RDY=1.

## Test plan
- Reset: RST=1 for 2 cycles with REQ=8'hFF and RDY=1 -> VLD=0, GNT=8'h00, SEL=0, O=0 throughout. The first grant after RST falls is requester 0.
- Single requester: REQ=8'h04, slice 2=4'hA, RDY=1 from idle -> after 1 edge GNT=8'h04, SEL=3'b010, O=4'hA, VLD=1. Dropping REQ at the acknowledge edge gives VLD=0 on the next cycle.
- Full rotation: REQ=8'hFF, RDY=1 held, slice i=i+1 -> SEL runs 0,1,…,7,0 one per cycle and O runs 1,2,…,8,1; VLD stays 1.
- Backpressure: granted on 3 with RDY=0 for 5 cycles while REQ and DIN toggle -> GNT=8'h08, SEL=3 and O stay stable. RDY=1 for one cycle -> next grant is the lowest set index above 3, with wrap.
- Wrap-around: grant 6 acknowledged, then REQ=8'h41 -> next grant is index 0 (PTR=7 searches 7,0), after which 6 is granted.
- Timeout (MUXARB_TIMEOUT_EN, TIMEOUT=4): grant on 1 with RDY=0 and REQ=8'h22 -> VLD is high for 4 cycles, then GNT=8'h20, SEL=5, and TOUT=1 for exactly 1 cycle.
